// File: rtl/bus_arbiter.sv
// Shared-memory arbiter: serialises dbg/ibus/dbus accesses onto one slave port.
// Each access takes three cycles: grant in IDLE, strobe in ACCESS, ack in RESP.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a request; winner's fields latched on grant
// ACCESS  | one-hot slave strobe driven from latched address/data/enables
// RESP    | winner's ack pulsed, read data muxed from the strobed slave
module bus_arbiter #(
  parameter int ADR_W      = 32,
  parameter int REGION_LSB = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             dbg_req,
  input  logic             ibus_req,
  input  logic             dbus_req,
  input  logic [ADR_W-1:0] dbg_adr,
  input  logic [ADR_W-1:0] ibus_adr,
  input  logic [ADR_W-1:0] dbus_adr,
  input  logic [31:0]      dbg_do,
  input  logic [31:0]      dbus_wdata,
  input  logic [3:0]       dbg_wren,
  input  logic [3:0]       dbus_wren,
  output logic             dbg_ack,
  output logic             ibus_ack,
  output logic             dbus_ack,
  output logic [31:0]      dbg_di,
  output logic [31:0]      ibus_rdata,
  output logic [31:0]      dbus_rdata,
  output logic             dbg_err,
  output logic             ibus_err,
  output logic             dbus_err,
  output logic [2:0]       s_sel,
  output logic [ADR_W-1:0] s_adr,
  output logic [31:0]      s_wdata,
  output logic [3:0]       s_wren,
  input  logic [31:0]      ram_rdata,
  input  logic [31:0]      mmio_rdata,
  input  logic [31:0]      rom_rdata
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Grant vector bit positions
  localparam int G_DBG  = 0;
  localparam int G_IBUS = 1;
  localparam int G_DBUS = 2;

  logic [1:0]       state_q, state_d;
  logic             rr_q, rr_d;      // 0: ibus preferred, 1: dbus preferred
  logic [2:0]       gnt_q, gnt_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wren_q, wren_d;

  logic             in_access, in_resp, unmapped;
  logic [1:0]       region;
  logic [31:0]      rdata_mux;

  assign in_access = (state_q == ST_ACCESS);
  assign in_resp   = (state_q == ST_RESP);
  assign region    = adr_q[REGION_LSB+1:REGION_LSB];
  assign unmapped  = (region == 2'd3);

  // Next-state, arbitration and request latching
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    wren_d  = wren_q;
    case (state_q)
      ST_IDLE: begin
        if (dbg_req) begin
          gnt_d   = 3'b001;
          adr_d   = dbg_adr;
          wdata_d = dbg_do;
          wren_d  = dbg_wren;
          state_d = ST_ACCESS;
        end else if (ibus_req && (!dbus_req || !rr_q)) begin
          gnt_d   = 3'b010;
          adr_d   = ibus_adr;
          wdata_d = '0;
          wren_d  = '0;      // instruction fetches are always reads
          rr_d    = 1'b1;
          state_d = ST_ACCESS;
        end else if (dbus_req) begin
          gnt_d   = 3'b100;
          adr_d   = dbus_adr;
          wdata_d = dbus_wdata;
          wren_d  = dbus_wren;
          rr_d    = 1'b0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and latched-access registers; reset also aborts any access in flight
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      gnt_q   <= '0;
      adr_q   <= '0;
      wdata_q <= '0;
      wren_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
    end
  end

  // Slave strobe decode; region 3 touches no slave
  always_comb begin
    s_sel = 3'b000;
    if (in_access) begin
      case (region)
        2'd0:    s_sel = 3'b001;
        2'd1:    s_sel = 3'b010;
        2'd2:    s_sel = 3'b100;
        default: s_sel = 3'b000;
      endcase
    end
  end

  assign s_adr   = in_access ? adr_q   : '0;
  assign s_wdata = in_access ? wdata_q : '0;
  assign s_wren  = in_access ? wren_q  : '0;

  // Read-data select by the region strobed in the previous cycle
  always_comb begin
    case (region)
      2'd0:    rdata_mux = ram_rdata;
      2'd1:    rdata_mux = mmio_rdata;
      2'd2:    rdata_mux = rom_rdata;
      default: rdata_mux = '0;
    endcase
  end

  assign dbg_ack    = in_resp & gnt_q[G_DBG];
  assign ibus_ack   = in_resp & gnt_q[G_IBUS];
  assign dbus_ack   = in_resp & gnt_q[G_DBUS];
  assign dbg_err    = dbg_ack  & unmapped;
  assign ibus_err   = ibus_ack & unmapped;
  assign dbus_err   = dbus_ack & unmapped;
  assign dbg_di     = dbg_ack  ? rdata_mux : '0;
  assign ibus_rdata = ibus_ack ? rdata_mux : '0;
  assign dbus_rdata = dbus_ack ? rdata_mux : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
`timescale 1ns/1ps
module tb_bus_arbiter;
  localparam int ADR_W      = 32;
  localparam int REGION_LSB = 16;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              dbg_req, ibus_req, dbus_req;
  logic [ADR_W-1:0]  dbg_adr, ibus_adr, dbus_adr;
  logic [31:0]       dbg_do, dbus_wdata;
  logic [3:0]        dbg_wren, dbus_wren;
  logic              dbg_ack, ibus_ack, dbus_ack;
  logic [31:0]       dbg_di, ibus_rdata, dbus_rdata;
  logic              dbg_err, ibus_err, dbus_err;
  logic [2:0]        s_sel;
  logic [ADR_W-1:0]  s_adr;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wren;
  logic [31:0]       ram_rdata  = 32'h0;
  logic [31:0]       mmio_rdata = 32'h0;
  logic [31:0]       rom_rdata  = 32'h0;

  int vectors     = 0;
  int miscompares = 0;

  // slave contents as seen by the DUT, and the bench's own expectation of them
  bit [31:0] slv_mem [0:2][0:16383];
  bit [31:0] exp_mem [0:2][0:16383];

  bus_arbiter #(.ADR_W(ADR_W), .REGION_LSB(REGION_LSB)) dut (
    .CLK(CLK), .RESET(RESET),
    .dbg_req(dbg_req), .ibus_req(ibus_req), .dbus_req(dbus_req),
    .dbg_adr(dbg_adr), .ibus_adr(ibus_adr), .dbus_adr(dbus_adr),
    .dbg_do(dbg_do), .dbus_wdata(dbus_wdata),
    .dbg_wren(dbg_wren), .dbus_wren(dbus_wren),
    .dbg_ack(dbg_ack), .ibus_ack(ibus_ack), .dbus_ack(dbus_ack),
    .dbg_di(dbg_di), .ibus_rdata(ibus_rdata), .dbus_rdata(dbus_rdata),
    .dbg_err(dbg_err), .ibus_err(ibus_err), .dbus_err(dbus_err),
    .s_sel(s_sel), .s_adr(s_adr), .s_wdata(s_wdata), .s_wren(s_wren),
    .ram_rdata(ram_rdata), .mmio_rdata(mmio_rdata), .rom_rdata(rom_rdata)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] be);
    logic [31:0] m;
    m = o;
    for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = n[8*b +: 8];
    return m;
  endfunction

  // Synchronous slaves: read data registered one cycle after the strobe
  always @(posedge CLK) begin
    if (s_sel[0]) begin
      ram_rdata <= slv_mem[0][s_adr[REGION_LSB-1:2]];
      slv_mem[0][s_adr[REGION_LSB-1:2]] <= merge(slv_mem[0][s_adr[REGION_LSB-1:2]], s_wdata, s_wren);
    end
    if (s_sel[1]) begin
      mmio_rdata <= slv_mem[1][s_adr[REGION_LSB-1:2]];
      slv_mem[1][s_adr[REGION_LSB-1:2]] <= merge(slv_mem[1][s_adr[REGION_LSB-1:2]], s_wdata, s_wren);
    end
    if (s_sel[2]) begin
      rom_rdata <= slv_mem[2][s_adr[REGION_LSB-1:2]];
      slv_mem[2][s_adr[REGION_LSB-1:2]] <= merge(slv_mem[2][s_adr[REGION_LSB-1:2]], s_wdata, s_wren);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    dbg_req = 0; ibus_req = 0; dbus_req = 0;
    dbg_adr = '0; ibus_adr = '0; dbus_adr = '0;
    dbg_do = '0; dbus_wdata = '0; dbg_wren = '0; dbus_wren = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RESET = 1;
    tick();
    tick();
    RESET = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    RESET = 1;
    dbg_req = 1; ibus_req = 1; dbus_req = 1;
    tick();
    tick();
    vectors++;
    if ({dbg_ack, ibus_ack, dbus_ack, dbg_err, ibus_err, dbus_err, s_sel, s_wren} !== 13'h0 ||
        s_adr !== '0 || s_wdata !== '0 || {dbg_di, ibus_rdata, dbus_rdata} !== 96'h0) begin
      miscompares++;
      $display("FAIL reset_hold ack=%b%b%b sel=%b wren=%h adr=%h wdata=%h, want all 0",
               dbg_ack, ibus_ack, dbus_ack, s_sel, s_wren, s_adr, s_wdata);
    end
    clear_inputs();
    RESET = 0;
    tick();
    vectors++;
    if ({dbg_ack, ibus_ack, dbus_ack, s_sel, s_wren} !== 10'h0 || s_adr !== '0) begin
      miscompares++;
      $display("FAIL reset_idle ack=%b%b%b sel=%b wren=%h adr=%h, want all 0",
               dbg_ack, ibus_ack, dbus_ack, s_sel, s_wren, s_adr);
    end
  endtask

  task automatic test_dbg_write_read();
    dbg_adr = 32'h0; dbg_do = 32'hAA; dbg_wren = 4'hF; dbg_req = 1;
    exp_mem[0][0] = 32'hAA;
    tick();
    vectors++;
    if (s_sel !== 3'b001 || s_wren !== 4'hF || s_wdata !== 32'hAA || s_adr !== 32'h0 || dbg_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL dbg_wr_access sel=%b wren=%h wdata=%h ack=%b, want 001 f 000000aa 0",
               s_sel, s_wren, s_wdata, dbg_ack);
    end
    tick();
    vectors++;
    if ({dbg_ack, dbg_err, s_sel} !== 5'b10_000) begin
      miscompares++;
      $display("FAIL dbg_wr_ack ack=%b err=%b sel=%b, want 1 0 000", dbg_ack, dbg_err, s_sel);
    end
    dbg_req = 0; dbg_wren = 4'h0; dbg_do = 32'h0;
    tick();
    dbg_req = 1;
    tick();
    vectors++;
    if (s_sel !== 3'b001 || s_wren !== 4'h0 || dbg_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL dbg_rd_access sel=%b wren=%h ack=%b, want 001 0 0", s_sel, s_wren, dbg_ack);
    end
    tick();
    vectors++;
    if ({dbg_ack, dbg_err} !== 2'b10 || dbg_di !== 32'hAA) begin
      miscompares++;
      $display("FAIL dbg_rd_ack ack=%b err=%b di=%h, want 1 0 000000aa", dbg_ack, dbg_err, dbg_di);
    end
    dbg_req = 0;
    tick();
  endtask

  task automatic test_region_decode();
    logic [31:0] adrs [2];
    logic [31:0] dats [2];
    logic [2:0]  sels [2];
    adrs[0] = 32'h0001_0000; dats[0] = 32'hBB; sels[0] = 3'b010;
    adrs[1] = 32'h0002_0020; dats[1] = 32'hCC; sels[1] = 3'b100;
    exp_mem[1][0] = 32'hBB;
    exp_mem[2][8] = 32'hCC;
    for (int i = 0; i < 2; i++) begin
      dbg_adr = adrs[i]; dbg_do = dats[i]; dbg_wren = 4'hF; dbg_req = 1;
      tick();
      vectors++;
      if (s_sel !== sels[i] || s_adr !== adrs[i]) begin
        miscompares++;
        $display("FAIL region_wr_sel[%0d] sel=%b adr=%h, want %b %h", i, s_sel, s_adr, sels[i], adrs[i]);
      end
      tick();
      dbg_req = 0; dbg_wren = 4'h0;
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      dbus_adr = adrs[i]; dbus_wren = 4'h0; dbus_req = 1;
      tick();
      vectors++;
      if (s_sel !== sels[i]) begin
        miscompares++;
        $display("FAIL region_rd_sel[%0d] sel=%b, want %b", i, s_sel, sels[i]);
      end
      tick();
      vectors++;
      if ({dbus_ack, dbus_err} !== 2'b10 || dbus_rdata !== dats[i]) begin
        miscompares++;
        $display("FAIL region_rd_data[%0d] ack=%b err=%b rdata=%h, want 1 0 %h",
                 i, dbus_ack, dbus_err, dbus_rdata, dats[i]);
      end
      dbus_req = 0;
      tick();
    end
  endtask

  task automatic test_round_robin();
    int last;
    do_reset();
    ibus_adr = 32'h0; dbus_adr = 32'h4; dbus_wren = 4'h0;
    ibus_req = 1; dbus_req = 1;
    last = -1;
    for (int i = 1; i <= 12; i++) begin
      logic ei, ed;
      tick();
      ei = (i == 2) || (i == 8);
      ed = (i == 5) || (i == 11);
      vectors++;
      if ({ibus_ack, dbus_ack, dbg_ack} !== {ei, ed, 1'b0}) begin
        miscompares++;
        $display("FAIL rr_ack cyc=%0d ibus=%b dbus=%b dbg=%b, want %b %b 0", i, ibus_ack, dbus_ack, dbg_ack, ei, ed);
      end
      if (ibus_ack || dbus_ack) begin
        vectors++;
        if ((ibus_ack && last == 1) || (dbus_ack && last == 2)) begin
          miscompares++;
          $display("FAIL rr_repeat cyc=%0d master %0d acked twice in a row", i, last);
        end
        last = ibus_ack ? 1 : 2;
      end
    end
    ibus_req = 0; dbus_req = 0;
    tick();
  endtask

  task automatic test_preemption();
    do_reset();
    dbg_adr = 32'h0; dbg_wren = 4'h0; ibus_adr = 32'h4; dbus_adr = 32'h8; dbus_wren = 4'h0;
    dbg_req = 1; ibus_req = 1; dbus_req = 1;
    for (int i = 1; i <= 9; i++) begin
      logic [2:0] e;
      tick();
      e = (i == 2) ? 3'b100 : (i == 5) ? 3'b010 : (i == 8) ? 3'b001 : 3'b000;
      vectors++;
      if ({dbg_ack, ibus_ack, dbus_ack} !== e) begin
        miscompares++;
        $display("FAIL preempt_ack cyc=%0d dbg/ibus/dbus=%b, want %b", i, {dbg_ack, ibus_ack, dbus_ack}, e);
      end
      if (dbg_ack)  dbg_req  = 0;
      if (ibus_ack) ibus_req = 0;
      if (dbus_ack) dbus_req = 0;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_unmapped();
    dbus_adr = 32'h0003_0000; dbus_wren = 4'h0; dbus_req = 1;
    tick();
    vectors++;
    if (s_sel !== 3'b000 || dbus_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL unmapped_sel sel=%b ack=%b, want 000 0", s_sel, dbus_ack);
    end
    tick();
    vectors++;
    if ({dbus_ack, dbus_err} !== 2'b11 || dbus_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL unmapped_ack ack=%b err=%b rdata=%h, want 1 1 00000000", dbus_ack, dbus_err, dbus_rdata);
    end
    dbus_req = 0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    dbus_adr = 32'h0; dbus_wren = 4'h0; dbus_req = 1;
    tick();
    vectors++;
    if (s_sel !== 3'b001) begin
      miscompares++;
      $display("FAIL rstmid_access sel=%b, want 001", s_sel);
    end
    RESET = 1;
    tick();
    vectors++;
    if ({dbg_ack, ibus_ack, dbus_ack, dbg_err, ibus_err, dbus_err, s_sel, s_wren} !== 13'h0 ||
        s_adr !== '0 || s_wdata !== '0 || {dbg_di, ibus_rdata, dbus_rdata} !== 96'h0) begin
      miscompares++;
      $display("FAIL rstmid_outputs dbus_ack=%b sel=%b wren=%h adr=%h, want all 0", dbus_ack, s_sel, s_wren, s_adr);
    end
    RESET = 0;
    tick();
    vectors++;
    if (s_sel !== 3'b001 || dbus_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_regrant sel=%b ack=%b, want 001 0", s_sel, dbus_ack);
    end
    tick();
    vectors++;
    if (dbus_ack !== 1'b1 || dbus_rdata !== 32'hAA) begin
      miscompares++;
      $display("FAIL rstmid_complete ack=%b rdata=%h, want 1 000000aa", dbus_ack, dbus_rdata);
    end
    dbus_req = 0;
    tick();
  endtask

  function automatic logic [31:0] rand_adr();
    logic [31:0] r;
    logic [1:0]  reg_f;
    logic [3:0]  idx;
    r = $urandom;
    reg_f = 2'($urandom_range(0, 3));
    idx = 4'($urandom_range(0, 15));
    return {r[31:18], reg_f, 10'd0, idx, r[1:0]};
  endfunction

  // Transaction-level model: a grant claims the port for three cycles; the
  // winner is the first requester in the preference list dbg, then the
  // round-robin favourite, then the other CPU port.
  task automatic test_random(int ncyc);
    int          g, who;
    bit          rr;
    int          pref [3];
    logic [2:0]  exp_sel, exp_acks;
    logic [31:0] exp_adr, exp_wdata, exp_rd;
    logic [3:0]  exp_wren;
    logic        exp_err;
    logic [95:0] exp_rvec;
    g = -10; who = 0; rr = 0;
    exp_sel = '0; exp_adr = '0; exp_wdata = '0; exp_rd = '0; exp_wren = '0; exp_err = 0;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      vectors++;
      if (c == g) begin
        if (s_sel !== exp_sel || s_adr !== exp_adr || s_wren !== exp_wren ||
            (exp_wren != 0 && s_wdata !== exp_wdata)) begin
          miscompares++;
          $display("FAIL rnd_strobe cyc=%0d sel=%b adr=%h wren=%h wdata=%h, want %b %h %h %h",
                   c, s_sel, s_adr, s_wren, s_wdata, exp_sel, exp_adr, exp_wren, exp_wdata);
        end
      end else if (s_sel !== 3'b000) begin
        miscompares++;
        $display("FAIL rnd_idle_sel cyc=%0d sel=%b, want 000", c, s_sel);
      end
      exp_acks = (c == g + 1) ? 3'(1 << who) : 3'b000;
      vectors++;
      if ({dbus_ack, ibus_ack, dbg_ack} !== exp_acks ||
          {dbus_err, ibus_err, dbg_err} !== (exp_err ? exp_acks : 3'b000)) begin
        miscompares++;
        $display("FAIL rnd_ack cyc=%0d ack(d,i,g)=%b err=%b, want %b err %b", c,
                 {dbus_ack, ibus_ack, dbg_ack}, {dbus_err, ibus_err, dbg_err}, exp_acks, exp_err);
      end
      exp_rvec = '0;
      if (c == g + 1) exp_rvec[32*who +: 32] = exp_rd;
      vectors++;
      if ({dbus_rdata, ibus_rdata, dbg_di} !== exp_rvec) begin
        miscompares++;
        $display("FAIL rnd_rdata cyc=%0d got d=%h i=%h g=%h, want %h", c, dbus_rdata, ibus_rdata, dbg_di, exp_rvec);
      end
      if (c == g + 1) begin
        if (who == 0) dbg_req = 0;
        if (who == 1) ibus_req = 0;
        if (who == 2) dbus_req = 0;
      end
      if (!dbg_req && $urandom_range(0, 7) == 0) begin
        dbg_adr = rand_adr(); dbg_do = $urandom;
        dbg_wren = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        dbg_req = 1;
      end
      if (!ibus_req && $urandom_range(0, 1) == 0) begin
        ibus_adr = rand_adr(); ibus_req = 1;
      end
      if (!dbus_req && $urandom_range(0, 1) == 0) begin
        dbus_adr = rand_adr(); dbus_wdata = $urandom;
        dbus_wren = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        dbus_req = 1;
      end
      if (c + 1 >= g + 3 && (dbg_req || ibus_req || dbus_req)) begin
        logic [2:0] reqs;
        int r, idx;
        reqs = {dbus_req, ibus_req, dbg_req};
        pref[0] = 0;
        pref[1] = rr ? 2 : 1;
        pref[2] = rr ? 1 : 2;
        who = -1;
        for (int k = 0; k < 3; k++) if (who < 0 && reqs[pref[k]]) who = pref[k];
        g = c + 1;
        if (who == 1) rr = 1;
        if (who == 2) rr = 0;
        exp_adr   = (who == 0) ? dbg_adr : (who == 1) ? ibus_adr : dbus_adr;
        exp_wdata = (who == 0) ? dbg_do : dbus_wdata;
        exp_wren  = (who == 0) ? dbg_wren : (who == 1) ? 4'h0 : dbus_wren;
        r   = int'(exp_adr[REGION_LSB+1:REGION_LSB]);
        idx = int'(exp_adr[REGION_LSB-1:2]);
        exp_err = (r == 3);
        exp_sel = (r == 3) ? 3'b000 : 3'(1 << r);
        exp_rd  = (r == 3) ? 32'h0 : exp_mem[r][idx];
        if (r != 3) exp_mem[r][idx] = merge(exp_rd, exp_wdata, exp_wren);
      end
      tick();
    end
    clear_inputs();
    tick(); tick(); tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    RESET = 1;
    test_reset();
    test_dbg_write_read();
    test_region_decode();
    test_round_robin();
    test_preemption();
    test_unmapped();
    test_reset_mid_access();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Shared-memory arbiter for the cvrisc SoC. It sits between three bus masters and the single memory port that serves the RAM, MMIO and ROM regions. The masters are the debug loader port, the CPU instruction bus and the CPU data bus. It serialises one access at a time, decodes the target region, returns read data and acknowledge to the winning master, and flags unmapped accesses.

## Interface

Parameters:
- ADR_W, 32, address width of all masters and of `s_adr`.
- REGION_LSB, 16, lowest address bit of the 2-bit region field `adr[REGION_LSB+1:REGION_LSB]`.

Ports:
- CLK  in  1  system clock; everything sampled on rising edge.
- RESET  in  1  synchronous, active-high reset.
- dbg_req / ibus_req / dbus_req  in  1 each  access request; must stay high with stable fields until the matching ack.
- dbg_adr / ibus_adr / dbus_adr  in  ADR_W each  byte address; bits [1:0] ignored.
- dbg_do / dbus_wdata  in  32 each  write data.
- dbg_wren / dbus_wren  in  4 each  byte write enables; 0 means read. ibus is always read.
- dbg_ack / ibus_ack / dbus_ack  out  1 each  one-cycle completion pulse.
- dbg_di / ibus_rdata / dbus_rdata  out  32 each  read data, valid only in the ack cycle.
- dbg_err / ibus_err / dbus_err  out  1 each  asserted with ack when the region is unmapped.
- s_sel  out  3  one-hot slave strobe: [0] RAM at region 0, [1] MMIO at region 1, [2] ROM at region 2.
- s_adr  out  ADR_W  address to slaves.
- s_wdata  out  32  write data to slaves.
- s_wren  out  4  byte enables to slaves.
- ram_rdata / mmio_rdata / rom_rdata  in  32 each  slave read data, valid exactly one cycle after strobe.

## Operation

- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - If any request is high, pick a winner, latch its adr/wdata/wren into registers, and go to ACCESS.
  - Otherwise stay in IDLE.
- **Priority**
  - dbg has absolute priority.
  - Between ibus and dbus, round-robin via a 1-bit `rr` pointer. `rr` selects the preferred master: 0 = ibus preferred, 1 = dbus preferred.
  - A granted ibus sets `rr` = 1. A granted dbus sets `rr` = 0.
  - A dbg grant leaves `rr` unchanged.
- **ACCESS** (exactly one cycle)
  - Drive `s_adr`, `s_wdata`, `s_wren` from the latched registers.
  - `s_sel` is one-hot by region. For region 3, `s_sel` = 0 (no slave touched).
  - Then go to RESP.
- **RESP** (exactly one cycle)
  - Pulse the winner's ack.
  - Drive the winner's rdata from the slave selected in ACCESS: latched region → ram/mmio/rom_rdata. Region 3 returns 0.
  - Assert err for region 3.
  - Then go to IDLE.
- Writes follow the same path. The rdata returned on a write is don't-care, but it must be the muxed slave value, not X.
- Non-winning masters see ack = 0 and err = 0. Their rdata outputs are 0 outside their own ack cycle.
- The ibus master never writes: `s_wren` = 0 whenever ibus is granted.

## Timing

- Request high at IDLE edge N → `s_sel` high in cycle N+1 → ack high in cycle N+2 → back in IDLE at N+3. A new grant can occur at the N+3 edge.
- Peak throughput: one access per 3 cycles.
- A request first raised while the FSM is busy waits. It is evaluated at the next IDLE cycle.
- A master dropping req before its ack is a protocol violation. The arbiter completes the latched access regardless.
- Simultaneous requests: dbg wins. With ibus and dbus both held continuously, grants alternate ibus, dbus, ibus, …
- Reset values:
  - state = IDLE; `rr` = 0 (ibus preferred).
  - All acks, errs, rdata outputs, `s_sel`, `s_wren` = 0.
  - `s_adr` and `s_wdata` = 0.
- Reset during ACCESS or RESP aborts the access: no ack is issued, and a write strobed in ACCESS may already have committed. On the cycle after RESET deasserts, arbitration restarts from IDLE.
- Region decode uses `adr[REGION_LSB+1:REGION_LSB]`. Higher address bits are ignored, so the map aliases.

## Test plan

- **Debug write then read:**
  - dbg writes 0xAA to 0x00000 with wren = F, then reads 0x00000.
  - Required: `s_sel` = 001 in the ACCESS cycle; dbg_ack exactly 2 cycles after grant; read returns dbg_di = 0x000000AA; err = 0.
- **Region decode:**
  - dbg writes 0xBB to 0x10000 and 0xCC to 0x20020.
  - Required: `s_sel` = 010 and 100 respectively.
  - dbus reads of the same addresses return 0xBB and 0xCC.
- **Round-robin:**
  - ibus and dbus requests held high for 12 cycles after reset.
  - Required: grant order ibus, dbus, ibus, dbus; one ack every 3 cycles; no master acked twice in a row.
- **Debug preemption:**
  - ibus, dbus and dbg all raise req in the same cycle.
  - Required: dbg_ack first; then ibus, since `rr` is unchanged from reset; then dbus.
- **Unmapped access:**
  - dbus reads 0x30000.
  - Required: `s_sel` = 000; dbus_ack together with dbus_err = 1; dbus_rdata = 0.
- **Reset mid-access:**
  - Assert RESET in the ACCESS cycle of a dbus read.
  - Required: no dbus_ack; all outputs 0 the cycle after reset is sampled.
  - After reset is released, the still-held dbus request completes normally 2 cycles after its new grant.
